// File: rtl/prio_arb_pkg.sv
// Shared state type and one-hot helper for the registered priority arbiter.
package prio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest arbiter the one-hot helper can describe; callers slice the result down to N.
    localparam int MAX_N = 64;

    function automatic logic [MAX_N-1:0] onehot_of(input int unsigned idx, input int unsigned n);
        logic [MAX_N-1:0] v;
        v = MAX_N'(1) << idx;
        if (idx >= n) begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational wrapped priority search: scans req downward from start
// (start, start-1, ..., 0, N-1, ...) and reports the first set line.
module prio_find
    import prio_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   window;
    logic [N-1:0]   scan;
    logic [W-1:0]   hit;
    int             pos;

    assign doubled = {req, req};

    // window[j] is req[(start+1+j) mod N], so the highest set bit of window is the winner.
    assign window = N'(doubled >> (32'(start) + 1));

    always_comb begin
        found = 1'b0;
        hit   = '0;
        scan  = window;
        for (int j = 0; j < N; j++) begin
            if (scan[0]) begin
                found = 1'b1;
                hit   = W'(j);
            end
            scan = scan >> 1;
        end
        pos = int'(start) + 1 + int'(hit);
        if (pos >= N) begin
            pos = pos - N;
        end
        idx = W'(pos);
    end

endmodule

// File: rtl/prio_arb_reg.sv
// Registered N-way priority arbiter with a valid/ready held grant.
// Define PRIO_ARB_ROUND_ROBIN_EN for round-robin search; the default build is fixed priority (highest index wins).
module prio_arb_reg
    import prio_arb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         grant_ready,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         idle
);

    arb_state_t   state;
    arb_state_t   state_next;
    logic         found;
    logic [W-1:0] win_idx;
    logic [W-1:0] search_start;
    logic         accept;
    logic         load;
    logic         clear;

    assign accept = (state == GRANT) && grant_ready;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [W-1:0] rr_ptr;
    logic [W-1:0] rr_next;

    // A back-to-back recapture on the accepting edge must already search past the winner just served.
    always_comb begin
        rr_next = rr_ptr;
        if (accept) begin
            rr_next = (grant_idx == '0) ? W'(N - 1) : grant_idx - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= W'(N - 1);
        end else begin
            rr_ptr <= rr_next;
        end
    end

    assign search_start = rr_next;
`else
    assign search_start = W'(N - 1);
`endif

    prio_find #(
        .N(N)
    ) u_find (
        .req   (req),
        .start (search_start),
        .found (found),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_next = found ? GRANT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // While a grant waits for grant_ready nothing loads, so the outputs stay frozen whatever req does.
    always_comb begin
        load  = 1'b0;
        clear = 1'b0;
        case (state)
            IDLE: begin
                load = found;
            end
            GRANT: begin
                if (grant_ready) begin
                    load  = found;
                    clear = !found;
                end
            end
            default: begin
                load  = 1'b0;
                clear = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            idle         <= 1'b1;
        end else begin
            idle <= (state == IDLE) && (req == '0);
            if (load) begin
                grant_valid  <= 1'b1;
                grant_idx    <= win_idx;
                grant_onehot <= N'(onehot_of(32'(win_idx), N));
            end else if (clear) begin
                grant_valid  <= 1'b0;
                grant_onehot <= '0;
            end
        end
    end

endmodule
